// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8-bit UART receiver with optional parity check.
// Ports: clk, reset (async, active-low), rx_in (serial, idles high),
//   data_out[7:0] (last byte, held), data_valid (1-cycle strobe),
//   parity_err / frame_err (qualify data_valid), busy (FSM not idle).
// Build option: define UART_RX_PARITY_EN for 8E1/8O1 frames;
//   left undefined the frame is 8N1 and parity_err is tied low.
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    r_data;
  logic [7:0]    w_data_nxt;
  logic          r_dv;
  logic          w_dv_nxt;
  logic          r_ferr;
  logic          w_ferr_nxt;
  logic          w_cnt_last;
  logic          w_cnt_half;

`ifdef UART_RX_PARITY_EN
  logic          r_perr;
  logic          w_perr_nxt;
  logic          r_perr_o;
  logic          w_perr_o_nxt;
`else
  logic          w_unused_par;
  assign w_unused_par = PARITY_ODD;
`endif

  // Two-flop synchronizer; idles high so reset
  // never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s     = r_sync2;
  assign w_cnt_last = (r_cnt == C_LAST);
  assign w_cnt_half = (r_cnt == C_HALF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_dv     <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr   <= 1'b0;
      r_perr_o <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_dv     <= w_dv_nxt;
      r_ferr   <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_perr   <= w_perr_nxt;
      r_perr_o <= w_perr_o_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_dv_nxt     = 1'b0;
    w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_nxt   = r_perr;
    w_perr_o_nxt = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Mid-bit check rejects short glitches.
        if (w_cnt_half) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = (^r_shift) ^ w_rx_s
                        ^ PARITY_ODD;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt    = '0;
          w_data_nxt   = r_shift;
          w_dv_nxt     = 1'b1;
          w_ferr_nxt   = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
          w_perr_o_nxt = r_perr;
`endif
          // A low stop bit may be a break; wait
          // for the line to rise before rearming.
          w_state_nxt  = w_rx_s ? S_IDLE
                                : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data_out   = r_data;
  assign data_valid = r_dv;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr_o;
`else
  assign parity_err = 1'b0;
`endif

endmodule
